axis_traffic_gen: RTL and testbench

Synthesizable multi-stream AXI-Stream traffic generator. It produces ramp, LFSR or constant packets on up to NUM_STREAMS independent lanes, with configurable packet length, packet count and periodic bubble insertion. It sits in FPGA test images and bench harnesses as the hardware counterpart to the simulation push tasks, driving DUT slave ports at line rate. Each lane honours its own tready independently.

---
 rtl/axis_traffic_gen.sv | 249 ++++++++++++++++++++++++
 tb/tb_axis_traffic_gen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: multi-lane AXI-Stream packet generator (ramp / LFSR / constant)
// with per-lane packet length, packet count, bubble insertion and graceful stop.
module axis_traffic_gen #(
    parameter int DWIDTH      = 32,
    parameter int NUM_STREAMS = 1,
    parameter int LEN_W       = 16,
    parameter int CNT_W       = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_stop,
    input  logic [1:0]                    i_mode,
    input  logic [NUM_STREAMS-1:0]        i_stream_en,
    input  logic [LEN_W-1:0]              i_pkt_len,
    input  logic [CNT_W-1:0]              i_num_pkts,
    input  logic [DWIDTH-1:0]             i_ramp_start,
    input  logic [DWIDTH-1:0]             i_ramp_inc,
    input  logic [LEN_W-1:0]              i_bubble_period,
    output logic [NUM_STREAMS*DWIDTH-1:0] o_m_tdata,
    output logic [NUM_STREAMS-1:0]        o_m_tvalid,
    output logic [NUM_STREAMS-1:0]        o_m_tlast,
    input  logic [NUM_STREAMS-1:0]        i_m_tready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [NUM_STREAMS*CNT_W-1:0]  o_pkt_cnt
);

    typedef enum logic [1:0] {G_IDLE = 2'd0, G_RUN = 2'd1, G_FLUSH = 2'd2} gstate_t;
    typedef enum logic [1:0] {L_OFF = 2'd0, L_SEND = 2'd1, L_BUBBLE = 2'd2, L_DONE = 2'd3} lstate_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One Galois step: shift right, fold taps in when the bit shifted out is 1.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    // Replicate the 32-bit LFSR state across the lane width (truncating the top).
    function automatic logic [DWIDTH-1:0] f_rep(input logic [31:0] s);
        logic [DWIDTH-1:0] r;
        for (int b = 0; b < DWIDTH; b++) begin
            r[b] = s[b % 32];
        end
        return r;
    endfunction

    // Zero-extend or truncate a data word to 32 bits for the LFSR seed.
    function automatic logic [31:0] f_to32(input logic [DWIDTH-1:0] v);
        logic [DWIDTH+31:0] t;
        t = {32'd0, v};
        return t[31:0];
    endfunction

    // Pick the word to present for the configured pattern; mode 3 behaves as ramp.
    function automatic logic [DWIDTH-1:0] f_sel_data(input logic [1:0] m,
                                                     input logic [DWIDTH-1:0] ramp,
                                                     input logic [31:0] lfsr,
                                                     input logic [DWIDTH-1:0] cst);
        case (m)
            2'd1:    return f_rep(lfsr);
            2'd2:    return cst;
            default: return ramp;
        endcase
    endfunction

    // Global control and captured configuration
    gstate_t             r_gstate;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_mode;
    logic [LEN_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_num;
    logic [DWIDTH-1:0]   r_rstart;
    logic [DWIDTH-1:0]   r_rinc;
    logic [LEN_W-1:0]    r_period;

    // Per-lane state
    lstate_t             r_lstate [NUM_STREAMS];
    logic [LEN_W-1:0]    r_idx    [NUM_STREAMS];
    logic [LEN_W-1:0]    r_bub    [NUM_STREAMS];
    logic [CNT_W-1:0]    r_cnt    [NUM_STREAMS];
    logic [31:0]         r_lfsr   [NUM_STREAMS];
    logic [DWIDTH-1:0]   r_ramp   [NUM_STREAMS];
    logic [DWIDTH-1:0]   r_tdata  [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] r_tvalid;
    logic [NUM_STREAMS-1:0] r_tlast;

    // Next-word and completion terms
    logic                   w_flush;
    logic [LEN_W-1:0]       w_len_eff;
    logic [LEN_W-1:0]       w_len_m1;
    logic [NUM_STREAMS-1:0] w_beat;
    logic [NUM_STREAMS-1:0] w_last;
    logic [NUM_STREAMS-1:0] w_fin_beat;
    logic [NUM_STREAMS-1:0] w_bub_hit;
    logic [NUM_STREAMS-1:0] w_lane_fin;
    logic                   w_all_fin;
    logic [CNT_W-1:0]       w_cnt_inc  [NUM_STREAMS];
    logic [LEN_W-1:0]       w_idx_nx   [NUM_STREAMS];
    logic [DWIDTH-1:0]      w_ramp_nx  [NUM_STREAMS];
    logic [31:0]            w_lfsr_nx  [NUM_STREAMS];
    logic [DWIDTH-1:0]      w_data_nx  [NUM_STREAMS];
    logic [31:0]            w_seed     [NUM_STREAMS];

    // Beat detection, next-word values and finish conditions for every lane
    always_comb begin
        w_flush   = (r_gstate == G_FLUSH) || ((r_gstate == G_RUN) && i_stop);
        w_len_eff = (i_pkt_len == '0) ? LEN_W'(1) : i_pkt_len;
        w_len_m1  = r_len - LEN_W'(1);
        for (int i = 0; i < NUM_STREAMS; i++) begin
            w_beat[i]     = (r_lstate[i] == L_SEND) && i_m_tready[i];
            w_last[i]     = (r_idx[i] == w_len_m1);
            w_cnt_inc[i]  = r_cnt[i] + CNT_W'(1);
            w_fin_beat[i] = w_beat[i] && w_last[i] &&
                            (((r_num != '0) && (w_cnt_inc[i] == r_num)) || w_flush);
            w_bub_hit[i]  = (r_period != '0) && ((r_bub[i] + LEN_W'(1)) == r_period);
            w_idx_nx[i]   = w_last[i] ? '0 : (r_idx[i] + LEN_W'(1));
            w_ramp_nx[i]  = w_last[i] ? r_rstart : (r_ramp[i] + r_rinc);
            w_lfsr_nx[i]  = f_lfsr_step(r_lfsr[i]);
            w_data_nx[i]  = f_sel_data(r_mode, w_ramp_nx[i], w_lfsr_nx[i], r_rstart);
            w_seed[i]     = f_to32(i_ramp_start) ^ 32'(i);
            w_seed[i]     = (w_seed[i] == 32'd0) ? 32'd1 : w_seed[i];
            // A lane is finished if it is already idle or will be after this edge.
            w_lane_fin[i] = (r_lstate[i] == L_OFF) || (r_lstate[i] == L_DONE) || w_fin_beat[i] ||
                            ((r_lstate[i] == L_BUBBLE) && w_flush && (r_idx[i] == '0));
        end
        w_all_fin = &w_lane_fin;
    end

    // Global FSM, config capture and per-lane generators
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_gstate <= G_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_mode   <= 2'd0;
            r_len    <= LEN_W'(1);
            r_num    <= '0;
            r_rstart <= '0;
            r_rinc   <= '0;
            r_period <= '0;
            r_tvalid <= '0;
            r_tlast  <= '0;
            for (int i = 0; i < NUM_STREAMS; i++) begin
                r_lstate[i] <= L_OFF;
                r_idx[i]    <= '0;
                r_bub[i]    <= '0;
                r_cnt[i]    <= '0;
                r_lfsr[i]   <= 32'd1;
                r_ramp[i]   <= '0;
                r_tdata[i]  <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_gstate)
                G_IDLE: begin
                    if (i_start) begin
                        r_gstate <= G_RUN;
                        r_busy   <= 1'b1;
                        r_mode   <= i_mode;
                        r_len    <= w_len_eff;
                        r_num    <= i_num_pkts;
                        r_rstart <= i_ramp_start;
                        r_rinc   <= i_ramp_inc;
                        r_period <= i_bubble_period;
                    end
                end
                G_RUN, G_FLUSH: begin
                    if (w_all_fin) begin
                        r_gstate <= G_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else if (i_stop) begin
                        r_gstate <= G_FLUSH;
                    end
                end
                default: r_gstate <= G_IDLE;
            endcase

            for (int i = 0; i < NUM_STREAMS; i++) begin
                if ((r_gstate == G_IDLE) && i_start) begin
                    r_lstate[i] <= i_stream_en[i] ? L_SEND : L_OFF;
                    r_tvalid[i] <= i_stream_en[i];
                    r_tlast[i]  <= i_stream_en[i] && (w_len_eff == LEN_W'(1));
                    r_idx[i]    <= '0;
                    r_bub[i]    <= '0;
                    r_cnt[i]    <= '0;
                    r_lfsr[i]   <= w_seed[i];
                    r_ramp[i]   <= i_ramp_start;
                    r_tdata[i]  <= f_sel_data(i_mode, i_ramp_start, w_seed[i], i_ramp_start);
                end else begin
                    case (r_lstate[i])
                        L_SEND: begin
                            if (w_beat[i]) begin
                                r_idx[i]   <= w_idx_nx[i];
                                r_ramp[i]  <= w_ramp_nx[i];
                                r_lfsr[i]  <= w_lfsr_nx[i];
                                r_tdata[i] <= w_data_nx[i];
                                r_tlast[i] <= (w_idx_nx[i] == w_len_m1);
                                if (w_last[i]) begin
                                    r_cnt[i] <= w_cnt_inc[i];
                                end
                                if (w_fin_beat[i]) begin
                                    r_lstate[i] <= L_DONE;
                                    r_tvalid[i] <= 1'b0;
                                    r_tlast[i]  <= 1'b0;
                                end else if (w_bub_hit[i]) begin
                                    r_lstate[i] <= L_BUBBLE;
                                    r_tvalid[i] <= 1'b0;
                                    r_bub[i]    <= '0;
                                end else begin
                                    r_bub[i] <= r_bub[i] + LEN_W'(1);
                                end
                            end
                        end
                        L_BUBBLE: begin
                            // Stop between packets ends the lane without a new word.
                            if (w_flush && (r_idx[i] == '0)) begin
                                r_lstate[i] <= L_DONE;
                                r_tlast[i]  <= 1'b0;
                            end else begin
                                r_lstate[i] <= L_SEND;
                                r_tvalid[i] <= 1'b1;
                            end
                        end
                        default: begin
                            r_lstate[i] <= r_lstate[i];
                        end
                    endcase
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_STREAMS; g++) begin : g_out
            assign o_m_tdata[g*DWIDTH +: DWIDTH] = r_tdata[g];
            assign o_pkt_cnt[g*CNT_W +: CNT_W]   = r_cnt[g];
        end
    endgenerate

    assign o_m_tvalid = r_tvalid;
    assign o_m_tlast  = r_tlast;
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: directed bench for axis_traffic_gen with two lanes.
module tb_axis_traffic_gen;

    localparam int DW = 32;
    localparam int NS = 2;
    localparam int LW = 16;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              i_rst_n;
    logic              i_start;
    logic              i_stop;
    logic [1:0]        i_mode;
    logic [NS-1:0]     i_stream_en;
    logic [LW-1:0]     i_pkt_len;
    logic [CW-1:0]     i_num_pkts;
    logic [DW-1:0]     i_ramp_start;
    logic [DW-1:0]     i_ramp_inc;
    logic [LW-1:0]     i_bubble_period;
    logic [NS*DW-1:0]  o_m_tdata;
    logic [NS-1:0]     o_m_tvalid;
    logic [NS-1:0]     o_m_tlast;
    logic [NS-1:0]     i_m_tready;
    logic              o_busy;
    logic              o_done;
    logic [NS*CW-1:0]  o_pkt_cnt;

    // Free-running clock
    always #5 clk = ~clk;

    axis_traffic_gen #(.DWIDTH(DW), .NUM_STREAMS(NS), .LEN_W(LW), .CNT_W(CW)) u_dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .i_stream_en(i_stream_en), .i_pkt_len(i_pkt_len),
        .i_num_pkts(i_num_pkts), .i_ramp_start(i_ramp_start), .i_ramp_inc(i_ramp_inc),
        .i_bubble_period(i_bubble_period), .o_m_tdata(o_m_tdata), .o_m_tvalid(o_m_tvalid),
        .o_m_tlast(o_m_tlast), .i_m_tready(i_m_tready), .o_busy(o_busy), .o_done(o_done),
        .o_pkt_cnt(o_pkt_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] bd [NS][256];
    logic        bl [NS][256];
    int          bn [NS];
    int          last_beat_cyc [NS];
    logic        prev_stall [NS];
    logic [31:0] prev_d [NS];
    logic        prev_l [NS];
    logic        vh [256];
    int          vn;
    int          done_cyc;
    logic        v0_seen;
    logic        rnd_rdy;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic clear_log();
        for (int l = 0; l < NS; l++) begin
            bn[l] = 0;
            last_beat_cyc[l] = -1;
            prev_stall[l] = 1'b0;
        end
        vn = 0;
        done_cyc = -1;
        v0_seen = 1'b0;
    endtask

    // Observe outputs for this cycle, log beats, check stall holding, then advance one edge.
    task automatic step();
        if (rnd_rdy) i_m_tready = 2'($urandom_range(0, 3));
        else         i_m_tready = '1;
        for (int l = 0; l < NS; l++) begin
            if (prev_stall[l]) begin
                chk_eq("hold_valid", 64'(o_m_tvalid[l]), 64'd1);
                chk_eq("hold_data", 64'(o_m_tdata[l*DW +: DW]), 64'(prev_d[l]));
                chk_eq("hold_last", 64'(o_m_tlast[l]), 64'(prev_l[l]));
            end
            if (o_m_tvalid[l] && i_m_tready[l]) begin
                if (bn[l] < 256) begin
                    bd[l][bn[l]] = o_m_tdata[l*DW +: DW];
                    bl[l][bn[l]] = o_m_tlast[l];
                    bn[l]++;
                end
                last_beat_cyc[l] = cyc;
            end
            prev_stall[l] = o_m_tvalid[l] && !i_m_tready[l];
            prev_d[l] = o_m_tdata[l*DW +: DW];
            prev_l[l] = o_m_tlast[l];
        end
        if (o_m_tvalid[0]) v0_seen = 1'b1;
        if (vn < 256) begin
            vh[vn] = o_m_tvalid[0];
            vn++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (o_done && done_cyc < 0) done_cyc = cyc;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (done_cyc < 0 && k < budget) begin
            step();
            k++;
        end
        chk_eq("done_seen", 64'(done_cyc >= 0), 64'd1);
    endtask

    task automatic do_start(input logic [1:0] m, input logic [NS-1:0] en, input int len,
                            input int num, input logic [31:0] rs, input logic [31:0] inc,
                            input int per);
        i_mode = m; i_stream_en = en; i_pkt_len = LW'(len); i_num_pkts = CW'(num);
        i_ramp_start = rs; i_ramp_inc = inc; i_bubble_period = LW'(per);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    initial begin
        logic [31:0] s;
        int k;
        i_rst_n = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_mode = 2'd0; i_stream_en = '0;
        i_pkt_len = '0; i_num_pkts = '0; i_ramp_start = '0; i_ramp_inc = '0;
        i_bubble_period = '0; i_m_tready = '1; rnd_rdy = 1'b0;
        clear_log();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_tvalid", 64'(o_m_tvalid), 64'd0);
        chk_eq("rst_tlast", 64'(o_m_tlast), 64'd0);
        chk_eq("rst_tdata", 64'(o_m_tdata), 64'd0);
        chk_eq("rst_busy", 64'(o_busy), 64'd0);
        chk_eq("rst_done", 64'(o_done), 64'd0);
        chk_eq("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
        i_rst_n = 1'b1;
        step();

        // Ramp, 2 packets of 4; stop arriving with start while idle is ignored.
        clear_log();
        i_stop = 1'b1;
        do_start(2'd0, 2'b01, 4, 2, 32'h10, 32'h2, 0);
        i_stop = 1'b0;
        chk_eq("t1_busy", 64'(o_busy), 64'd1);
        chk_eq("t1_first_valid", 64'(o_m_tvalid), 64'd1);
        chk_eq("t1_first_data", 64'(o_m_tdata[31:0]), 64'h10);
        run_until_done(40);
        chk_eq("t1_beats", 64'(bn[0]), 64'd8);
        for (int j = 0; j < 8; j++) begin
            chk_eq("t1_data", 64'(bd[0][j]), 64'(32'h10 + 32'(2 * (j % 4))));
            chk_eq("t1_last", 64'(bl[0][j]), 64'((j % 4) == 3));
        end
        chk_eq("t1_done_time", 64'(done_cyc), 64'(last_beat_cyc[0] + 1));
        chk_eq("t1_busy_at_done", 64'(o_busy), 64'd0);
        chk_eq("t1_pkt_cnt0", 64'(o_pkt_cnt[31:0]), 64'd2);
        chk_eq("t1_pkt_cnt1", 64'(o_pkt_cnt[63:32]), 64'd0);
        step();
        chk_eq("t1_done_pulse", 64'(o_done), 64'd0);

        // Bubbles every 3 words, pkt_len 5, unlimited; stop in packet 2.
        clear_log();
        do_start(2'd0, 2'b01, 5, 0, 32'h0, 32'h1, 3);
        k = 0;
        while (bn[0] < 7 && k < 30) begin
            step();
            k++;
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        run_until_done(30);
        chk_eq("t2_beats", 64'(bn[0]), 64'd10);
        for (int j = 0; j < 10; j++) begin
            chk_eq("t2_data", 64'(bd[0][j]), 64'(j % 5));
            chk_eq("t2_last", 64'(bl[0][j]), 64'((j % 5) == 4));
        end
        for (int j = 1; j < 14; j++) begin
            chk_eq("t2_valid_pattern", 64'(vh[j]), 64'((j % 4) != 0));
        end
        chk_eq("t2_done_time", 64'(done_cyc), 64'(last_beat_cyc[0] + 1));

        // LFSR on both lanes with independent random tready.
        clear_log();
        rnd_rdy = 1'b1;
        i_m_tready = '0;
        do_start(2'd1, 2'b11, 7, 0, 32'h0, 32'h0, 0);
        chk_eq("t3_seed0", 64'(o_m_tdata[31:0]), 64'd1);
        chk_eq("t3_seed1", 64'(o_m_tdata[63:32]), 64'd1);
        k = 0;
        while ((bn[0] < 100 || bn[1] < 100) && k < 2000) begin
            step();
            k++;
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        run_until_done(200);
        rnd_rdy = 1'b0;
        for (int l = 0; l < NS; l++) begin
            chk_eq("t3_count", 64'(bn[l] >= 100), 64'd1);
            chk_eq("t3_whole_pkts", 64'(bn[l] % 7), 64'd0);
            s = 32'd1;
            for (int j = 0; j < 100; j++) begin
                chk_eq("t3_lfsr", 64'(bd[l][j]), 64'(s));
                chk_eq("t3_last", 64'(bl[l][j]), 64'((j % 7) == 6));
                s = lfsr_next(s);
            end
        end

        // Lane 0 disabled, lane 1 one packet of pkt_len 0 (treated as 1).
        clear_log();
        do_start(2'd0, 2'b10, 0, 1, 32'hAB, 32'h1, 0);
        run_until_done(20);
        chk_eq("t4_lane0_quiet", 64'(v0_seen), 64'd0);
        chk_eq("t4_beats", 64'(bn[1]), 64'd1);
        chk_eq("t4_data", 64'(bd[1][0]), 64'hAB);
        chk_eq("t4_last", 64'(bl[1][0]), 64'd1);
        chk_eq("t4_pkt_cnt1", 64'(o_pkt_cnt[63:32]), 64'd1);
        chk_eq("t4_done_time", 64'(done_cyc), 64'(last_beat_cyc[1] + 1));

        // Reset mid-packet, then a fresh run.
        clear_log();
        do_start(2'd0, 2'b01, 8, 0, 32'h55, 32'h1, 0);
        repeat (3) step();
        i_rst_n = 1'b0;
        step();
        chk_eq("t5_rst_tvalid", 64'(o_m_tvalid), 64'd0);
        chk_eq("t5_rst_tlast", 64'(o_m_tlast), 64'd0);
        chk_eq("t5_rst_tdata", 64'(o_m_tdata), 64'd0);
        chk_eq("t5_rst_busy", 64'(o_busy), 64'd0);
        i_rst_n = 1'b1;
        step();
        clear_log();
        do_start(2'd0, 2'b01, 4, 1, 32'h20, 32'h1, 0);
        chk_eq("t5_pkt_cnt_clear", 64'(o_pkt_cnt[31:0]), 64'd0);
        chk_eq("t5_first_data", 64'(o_m_tdata[31:0]), 64'h20);
        run_until_done(20);
        chk_eq("t5_beats", 64'(bn[0]), 64'd4);
        chk_eq("t5_d0", 64'(bd[0][0]), 64'h20);
        chk_eq("t5_d3", 64'(bd[0][3]), 64'h23);
        chk_eq("t5_last3", 64'(bl[0][3]), 64'd1);
        chk_eq("t5_pkt_cnt", 64'(o_pkt_cnt[31:0]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
